// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stage sequencer for an N-stage CPU datapath.
// It runs in one of two modes:
//   - sequential: one instruction in flight, advanced by a phase counter;
//   - pipelined: per-stage valid bits, hazard stalls, memory freeze and
//     redirect flushes.
// Optional feature macro: PERF_COUNTER_EN enables the retired/stall counters.
// When the macro is undefined, both counter ports read as zero and no
// counter flops are built.
module pipeline_sequencer #(
  parameter int unsigned STAGES         = 5,
  parameter int unsigned ID_STAGE       = 1,
  parameter int unsigned MEM_STAGE      = 3,
  parameter int unsigned REDIRECT_STAGE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              hazard,
  input  logic              redirect,
  input  logic              mem_ready,
  input  logic              halt,
  output logic              pc_wren,
  output logic              pc_redirect,
  output logic [STAGES-2:0] stage_wren,
  output logic [STAGES-2:0] stage_clear,
  output logic [STAGES-1:0] stage_valid,
  output logic              ram_wren,
  output logic              reg_wren,
  output logic              busy,
  output logic              halted,
  output logic [31:0]       retired_count,
  output logic [31:0]       stall_count
);

  localparam int unsigned PW   = $clog2(STAGES);
  localparam int unsigned LAST = STAGES - 1;

  typedef enum logic [1:0] {
    START  = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q;
  logic [PW-1:0]     p_q, p_d;
  logic [STAGES-1:1] valid_q, valid_d;
  logic [STAGES-1:0] pipe_sv;
  logic              active, pipe, fetch, seq_run, seq_wait;
  logic              freeze, redir_take, hz_take;

  // Reset blanks every enable in the cycle it is asserted, aborting any instruction.
  assign active     = (state_q == RUN || state_q == DRAIN) && !reset;
  assign pipe       = active && mode_q;
  assign fetch      = pipe && state_q == RUN && !halt;
  assign pipe_sv    = {valid_q, fetch};
  // Sequential halt takes effect only between instructions (p = 0).
  assign seq_run    = active && !mode_q && state_q == RUN && !(p_q == '0 && halt);
  assign seq_wait   = seq_run && p_q == PW'(MEM_STAGE) && !mem_ready;
  // Pipelined priority: freeze > redirect > hazard > normal.
  assign freeze     = pipe && pipe_sv[MEM_STAGE] && !mem_ready;
  assign redir_take = pipe && !freeze && pipe_sv[REDIRECT_STAGE] && redirect;
  assign hz_take    = pipe && !freeze && !redir_take && pipe_sv[ID_STAGE] && hazard;

  assign busy   = |stage_valid[STAGES-1:1];
  assign halted = state_q == HALTED && !reset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= START;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      START:   state_d = RUN;
      RUN:     if (halt && (mode_q || p_q == '0)) state_d = DRAIN;
      DRAIN:   if (!busy) state_d = HALTED;
               else if (!halt) state_d = RUN;
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = START;
    endcase
  end

  // Enable outputs, decoded from registered state and current inputs.
  always_comb begin
    pc_wren     = 1'b0;
    pc_redirect = 1'b0;
    stage_wren  = '0;
    stage_clear = '0;
    ram_wren    = 1'b0;
    reg_wren    = 1'b0;
    stage_valid = '0;
    if (seq_run) begin
      for (int unsigned i = 0; i < STAGES; i++) stage_valid[i] = (p_q == PW'(i));
      if (!seq_wait) begin
        for (int unsigned i = 0; i < LAST; i++) stage_wren[i] = (p_q == PW'(i));
        ram_wren = (p_q == PW'(MEM_STAGE));
        if (p_q == PW'(LAST)) begin
          pc_wren     = 1'b1;
          pc_redirect = 1'b1;
          reg_wren    = 1'b1;
        end
      end
    end else if (pipe) begin
      stage_valid = pipe_sv;
      if (redir_take) begin
        pc_wren     = 1'b1;
        pc_redirect = 1'b1;
        stage_wren  = '1;
        for (int unsigned i = 0; i < REDIRECT_STAGE; i++) stage_clear[i] = 1'b1;
      end else if (hz_take) begin
        for (int unsigned i = ID_STAGE; i < LAST; i++) stage_wren[i] = 1'b1;
        stage_clear[ID_STAGE] = 1'b1;
      end else if (!freeze) begin
        pc_wren    = 1'b1;
        stage_wren = '1;
      end
      // Not fetching (draining): hold the PC and inject bubbles behind IF.
      if (!fetch) begin
        pc_wren        = 1'b0;
        stage_clear[0] = 1'b1;
      end
      ram_wren = pipe_sv[MEM_STAGE] && mem_ready;
      reg_wren = pipe_sv[LAST] && !freeze;
    end
  end

  // Next phase and next valid bits follow the enables just decoded.
  always_comb begin
    p_d     = p_q;
    valid_d = valid_q;
    if (seq_run && !seq_wait) p_d = (p_q == PW'(LAST)) ? '0 : p_q + PW'(1);
    if (pipe) begin
      for (int unsigned i = 0; i < LAST; i++)
        if (stage_wren[i]) valid_d[i+1] = pipe_sv[i] && !stage_clear[i];
    end
  end

  // Phase counter, valid bits and latched mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q     <= '0;
      valid_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      p_q     <= p_d;
      valid_q <= valid_d;
      if (state_q == START) mode_q <= mode;
    end
  end

`ifdef PERF_COUNTER_EN
  logic [31:0] retired_q, stall_q;

  // Retired-instruction and lost-cycle counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      if (reg_wren) retired_q <= retired_q + 32'd1;
      if (freeze || hz_take || seq_wait) stall_q <= stall_q + 32'd1;
    end
  end

  assign retired_count = retired_q;
  assign stall_count   = stall_q;
`else
  assign retired_count = 32'd0;
  assign stall_count   = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer (STAGES = 5): directed vectors push
// expected outputs, a negedge monitor pops and compares.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1, mode = 1'b0, hazard = 1'b0, redirect = 1'b0;
  logic        mem_ready = 1'b1, halt = 1'b0;
  logic        pc_wren, pc_redirect, ram_wren, reg_wren, busy, halted;
  logic [3:0]  stage_wren, stage_clear;
  logic [4:0]  stage_valid;
  logic [31:0] retired_count, stall_count;

`ifdef PERF_COUNTER_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipeline_sequencer dut (
    .clk(clk), .reset(reset), .mode(mode), .hazard(hazard), .redirect(redirect),
    .mem_ready(mem_ready), .halt(halt), .pc_wren(pc_wren), .pc_redirect(pc_redirect),
    .stage_wren(stage_wren), .stage_clear(stage_clear), .stage_valid(stage_valid),
    .ram_wren(ram_wren), .reg_wren(reg_wren), .busy(busy), .halted(halted),
    .retired_count(retired_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] exp;
    bit          cc;
    logic [31:0] ret;
    logic [31:0] stl;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  exp_t        mon_e;
  logic [18:0] mon_act;

  // {pc_wren, pc_redirect, stage_wren, stage_clear, ram_wren, reg_wren, busy, halted, stage_valid}
  function automatic logic [18:0] mk(logic pc, logic rd, logic [3:0] sw, logic [3:0] sc,
                                     logic ram, logic rg, logic bz, logic hl, logic [4:0] sv);
    return {pc, rd, sw, sc, ram, rg, bz, hl, sv};
  endfunction

  task automatic step(input logic r, input logic h, input logic hz, input logic rd,
                      input logic mr, input logic [18:0] e, input string nm,
                      input bit cc = 1'b0, input int ret = 0, input int stl = 0);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r; halt = h; hazard = hz; redirect = rd; mem_ready = mr;
    x.exp = e; x.cc = cc; x.nm = nm;
    x.ret = PERF ? 32'(ret) : 32'd0;
    x.stl = PERF ? 32'(stl) : 32'd0;
    sb.push_back(x);
  endtask

  // Monitor: compare outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      mon_act = {pc_wren, pc_redirect, stage_wren, stage_clear, ram_wren, reg_wren,
                 busy, halted, stage_valid};
      checks++;
      if (mon_act !== mon_e.exp) begin
        failures++;
        $display("FAIL %s: outputs got %b want %b", mon_e.nm, mon_act, mon_e.exp);
      end
      if (mon_e.cc) begin
        checks++;
        if (retired_count !== mon_e.ret || stall_count !== mon_e.stl) begin
          failures++;
          $display("FAIL %s_cnt: retired/stall got %0d/%0d want %0d/%0d", mon_e.nm,
                   retired_count, stall_count, mon_e.ret, mon_e.stl);
        end
      end
    end
  end

  logic [18:0] seq_tab [5];
  logic [18:0] z, seq_w, full_v, halt_v;

  initial begin
    z      = '0;
    seq_tab[0] = mk(0, 0, 4'b0001, 4'b0000, 0, 0, 0, 0, 5'b00001);
    seq_tab[1] = mk(0, 0, 4'b0010, 4'b0000, 0, 0, 1, 0, 5'b00010);
    seq_tab[2] = mk(0, 0, 4'b0100, 4'b0000, 0, 0, 1, 0, 5'b00100);
    seq_tab[3] = mk(0, 0, 4'b1000, 4'b0000, 1, 0, 1, 0, 5'b01000);
    seq_tab[4] = mk(1, 1, 4'b0000, 4'b0000, 0, 1, 1, 0, 5'b10000);
    seq_w  = mk(0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0, 5'b01000);
    full_v = mk(1, 0, 4'b1111, 4'b0000, 1, 1, 1, 0, 5'b11111);
    halt_v = mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1, 5'b00000);

    // Sequential, mem_ready = 1
    mode = 1'b0;
    step(1, 0, 0, 0, 1, z, "reset");
    step(0, 0, 0, 0, 1, z, "start", 1'b1, 0, 0);
    for (int c = 0; c < 10; c++) step(0, 0, 0, 0, 1, seq_tab[c % 5], "seq_run");
    step(0, 0, 0, 0, 1, seq_tab[0], "seq_10cyc", 1'b1, 2, 0);
    for (int c = 1; c < 4; c++) step(0, 0, 0, 0, 1, seq_tab[c], "seq_run2");
    // Reset while at p = 4 must suppress the WB strobes
    step(1, 0, 0, 0, 1, z, "reset_abort");
    step(0, 0, 0, 0, 1, z, "start_after_abort", 1'b1, 0, 0);

    // Sequential with a three-cycle memory wait at p = 3
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 1, seq_tab[c], "seqw_run");
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0, seq_w, "seqw_wait");
    step(0, 0, 0, 0, 1, seq_tab[3], "seqw_mem");
    step(0, 0, 0, 0, 1, seq_tab[4], "seqw_wb");
    step(0, 0, 0, 0, 1, seq_tab[0], "seqw_next", 1'b1, 1, 3);

    // Pipelined fill
    mode = 1'b1;
    step(1, 0, 0, 0, 1, z, "reset_pipe");
    step(0, 0, 0, 0, 1, z, "start_pipe", 1'b1, 0, 0);
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0, 5'b00001), "fill1");
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 0, 0, 1, 0, 5'b00011), "fill2");
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 0, 0, 1, 0, 5'b00111), "fill3");
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 1, 0, 1, 0, 5'b01111), "fill4");
    for (int c = 0; c < 6; c++) step(0, 0, 0, 0, 1, full_v, "full");
    // Single-cycle hazard
    step(0, 0, 1, 0, 1, mk(0, 0, 4'b1110, 4'b0010, 1, 1, 1, 0, 5'b11111), "hazard", 1'b1, 6, 0);
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 1, 1, 1, 0, 5'b11011), "hz_bubble", 1'b1, 7, 1);
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 0, 1, 1, 0, 5'b10111), "hz_bubble2");
    // Redirect and hazard together: redirect wins
    step(0, 0, 1, 1, 1, mk(1, 1, 4'b1111, 4'b0111, 1, 0, 1, 0, 5'b01111), "redirect");
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 0, 1, 1, 0, 5'b10001), "redir_flush", 1'b1, 9, 1);
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 0, 0, 1, 0, 5'b00011), "refill2");
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 0, 0, 1, 0, 5'b00111), "refill3");
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 1, 0, 1, 0, 5'b01111), "refill4");
    step(0, 0, 0, 0, 1, full_v, "refull");
    // Halt on a full pipeline and drain
    step(0, 1, 0, 0, 1, mk(0, 0, 4'b1111, 4'b0001, 1, 1, 1, 0, 5'b11110), "halt0");
    step(0, 1, 0, 0, 1, mk(0, 0, 4'b1111, 4'b0001, 1, 1, 1, 0, 5'b11100), "drain1");
    step(0, 1, 0, 0, 1, mk(0, 0, 4'b1111, 4'b0001, 1, 1, 1, 0, 5'b11000), "drain2");
    step(0, 1, 0, 0, 1, mk(0, 0, 4'b1111, 4'b0001, 0, 1, 1, 0, 5'b10000), "drain3");
    step(0, 1, 0, 0, 1, mk(0, 0, 4'b1111, 4'b0001, 0, 0, 0, 0, 5'b00000), "drain_empty");
    step(0, 1, 0, 0, 1, halt_v, "halted", 1'b1, 15, 1);
    step(0, 0, 0, 0, 1, halt_v, "halted_release");
    // Restart, then memory freeze
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0, 5'b00001), "restart1");
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 0, 0, 1, 0, 5'b00011), "restart2");
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 0, 0, 1, 0, 5'b00111), "restart3");
    step(0, 0, 0, 0, 0, mk(0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0, 5'b01111), "freeze");
    step(0, 0, 0, 0, 1, mk(1, 0, 4'b1111, 4'b0000, 1, 0, 1, 0, 5'b01111), "unfreeze", 1'b1, 15, 2);
    step(0, 0, 0, 0, 1, full_v, "refull2");
    step(0, 0, 0, 0, 0, mk(0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0, 5'b11111), "freeze_wb");
    step(0, 0, 0, 0, 1, full_v, "after_freeze", 1'b1, 16, 3);

    // Let the monitor consume the last entry, bounded to a few cycles
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_queue: pending %0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Parametrised stage sequencer for the CPU core, generalising the fixed five-stage stage controller. It drives the PC write enable, every pipeline-register write enable and clear, and the RAM and register-file write strobes for an N-stage datapath. It runs in one of two modes: sequential, with one instruction in flight, or pipelined, with per-stage valid tracking, hazard stalls, memory wait-states and branch flushes.

## Interface
- STAGES, 5: number of pipeline stages, at least 3. Stage 0 is IF; stage STAGES-1 is WB.
- ID_STAGE, 1: stage in which `hazard` is detected.
- MEM_STAGE, 3: stage that accesses RAM. Must satisfy ID_STAGE < MEM_STAGE < STAGES-1.
- REDIRECT_STAGE, 3: stage in which `redirect` is resolved. Must satisfy ID_STAGE < REDIRECT_STAGE ≤ MEM_STAGE.
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- mode  in  1  0 = sequential, 1 = pipelined. Sampled only in START.
- hazard  in  1  data hazard at ID_STAGE; meaningful in pipelined mode only.
- redirect  in  1  control transfer taken at REDIRECT_STAGE.
- mem_ready  in  1  RAM access done. 0 stalls the MEM_STAGE instruction.
- halt  in  1  stop fetching new instructions.
- pc_wren  out  1  PC load.
- pc_redirect  out  1  PC mux select: 1 = take the resolved target, 0 = PC+4.
- stage_wren  out  STAGES-1  bit i loads the register between stage i and stage i+1.
- stage_clear  out  STAGES-1  bit i loads a bubble (all zeros) into register i. Qualified by stage_wren[i].
- stage_valid  out  STAGES  per-stage valid bits. Bit 0 = 1 whenever fetching.
- ram_wren  out  1  RAM write strobe, gated externally with the decoded store.
- reg_wren  out  1  register-file write strobe, gated externally with the decoded rd write.
- busy  out  1  at least one valid instruction past IF.
- halted  out  1  pipeline empty and halted.
- retired_count  out  32  instructions completed in WB.
- stall_count  out  32  cycles lost to hazard or mem_ready.

## Operation
- FSM states: START, RUN, DRAIN, HALTED.
  - reset → START.
  - START → RUN after one cycle. On this edge `mode` is latched into mode_q.
  - RUN → DRAIN when `halt` is 1.
  - DRAIN → HALTED when busy = 0.
  - HALTED → RUN when `halt` = 0.
  - DRAIN → RUN if `halt` drops before the pipeline empties.
- In START and HALTED, every enable output is 0.
- Sequential mode (mode_q = 0): a phase counter p runs 0..STAGES-1 and wraps to 0.
  - p < STAGES-1: stage_wren[p] = 1.
  - p = MEM_STAGE: ram_wren = 1. p holds while mem_ready = 0, with all enables 0 during the wait.
  - p = STAGES-1: reg_wren = 1, pc_wren = 1, pc_redirect = 1 (the WB-computed next PC is always taken).
  - `hazard` and `redirect` are ignored.
  - `halt` is honoured only at p = 0.
- Pipelined mode (mode_q = 1): priority per cycle is freeze > redirect > hazard > normal.
  - **freeze** (stage_valid[MEM_STAGE] & ~mem_ready): all enables 0, valid bits held, stall_count increments.
  - **redirect** (stage_valid[REDIRECT_STAGE] & redirect):
    - pc_wren = 1, pc_redirect = 1.
    - All stage_wren = 1.
    - stage_clear[0..REDIRECT_STAGE-1] = 1, so valid[1..REDIRECT_STAGE] = 0 next cycle.
  - **hazard** (stage_valid[ID_STAGE] & hazard):
    - pc_wren = 0; stage_wren[0..ID_STAGE-1] = 0.
    - stage_wren[ID_STAGE..] = 1, with stage_clear[ID_STAGE] = 1.
    - stall_count increments.
  - **normal**: pc_wren = 1, all stage_wren = 1, valid shifts up by one stage.
  - ram_wren = stage_valid[MEM_STAGE] & mem_ready.
  - reg_wren = stage_valid[STAGES-1] & not frozen.
  - In DRAIN: pc_wren = 0 and stage_clear[0] = 1, so bubbles enter the pipeline.
- retired_count increments when reg_wren = 1 (sequential mode: at p = STAGES-1).
- Both counters wrap modulo 2^32.

## Timing
- All enable outputs are combinational from registered state (state, p, valid bits) and the current inputs. No input-to-state path inside the block is longer than one cycle.
- Reset values:
  - state = START, p = 0, stage_valid = 0.
  - busy = 0, halted = 0.
  - all enables 0, both counters 0.
- Reset asserted mid-instruction aborts it: no ram_wren or reg_wren is issued in the reset cycle or in START.
- Sequential latency: STAGES cycles per instruction plus the mem_ready wait cycles.
- Pipelined latency:
  - A new fetch every cycle when there are no stalls; an instruction reaches WB STAGES-1 cycles after its fetch.
  - A redirect costs REDIRECT_STAGE bubbles.
  - A hazard costs one bubble per asserted cycle.
- halted rises the cycle after busy reaches 0 in DRAIN.

## Configuration
- PERF_COUNTER_EN defined: retired_count and stall_count are implemented as above.
- PERF_COUNTER_EN undefined: both ports remain present and are tied to 0; no counter flops are generated.

## Test plan
All scenarios use STAGES = 5.
- **Sequential, mem_ready = 1:** stage_wren pulses 0001, 0010, 0100, 1000 on cycles 1–4 after START. ram_wren pulses on cycle 4 (p = 3) and reg_wren/pc_wren on cycle 5. With PERF_COUNTER_EN, retired_count = 2 after 10 cycles.
- **Sequential, mem_ready held 0 for 3 cycles at p = 3:** p holds for 3 cycles with all enables 0, then resumes. One instruction then takes 8 cycles.
- **Pipelined, no hazards:** stage_valid fills 00001 → 11111 over 4 cycles. reg_wren = 1 every cycle from cycle 5; retired_count = 6 after 10 cycles.
- **Pipelined, hazard for 1 cycle with valid[1] = 1:** pc_wren = 0, stage_wren = 1110, stage_clear = 0010. Next cycle valid[2] = 0; stall_count = 1.
- **Pipelined, redirect with valid[3] = 1 and hazard = 1 in the same cycle:** redirect wins. pc_redirect = 1, stage_clear = 0111, and valid[1..3] = 0 next cycle.
- **halt = 1 on a full pipeline:** pc_wren = 0 immediately. busy falls after 4 cycles, halted = 1 on the cycle after, and reg_wren pulses exactly 4 times during the drain.
